// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants and write-back types for the write-back arbiter.
// Latency: none (definitions only).
// Backpressure: n/a.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // One register-file write: destination plus data.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    // Round-robin successor of a requester index.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin grant selection: the first requesting index at or after ptr wins.
// Latency: purely combinational.
// Backpressure: grant is one-hot or zero; losers simply see no grant.
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] grant_idx
);

    // Walk the requesters starting at ptr, wrapping, and keep the first hit.
    always_comb begin
        int   idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ write-back sources and tracks pending writes per register.
// Latency: accepted write appears on wb_* one cycle later; ready/busy/claim_ready are combinational.
// Backpressure: one requester accepted per cycle (round-robin); claims refused while a counter is saturated.
// Optional forwarding outputs q_fwd/q_fwd_data are enabled by REGFILE_WB_ARB_BYPASS_EN.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int CNT_W = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ*REG_ADDR_W-1:0]   req_addr,
    input  logic [NREQ*REG_DATA_W-1:0]   req_data,
    input  logic                         claim_valid,
    input  logic [REG_ADDR_W-1:0]        claim_addr,
    output logic                         claim_ready,
    input  logic [REG_ADDR_W-1:0]        q_addr_a,
    input  logic [REG_ADDR_W-1:0]        q_addr_b,
    input  logic [REG_ADDR_W-1:0]        q_addr_c,
    output logic                         q_busy_a,
    output logic                         q_busy_b,
    output logic                         q_busy_c,
    output logic                         wb_we,
    output logic [REG_ADDR_W-1:0]        wb_addr,
    output logic [REG_DATA_W-1:0]        wb_din
`ifdef REGFILE_WB_ARB_BYPASS_EN
    ,
    output logic [2:0]                   q_fwd,
    output logic [3*REG_DATA_W-1:0]      q_fwd_data
`endif
);

    localparam int PTR_W = $clog2(NREQ);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PTR_W-1:0]    ptr;
    logic [NREQ-1:0]     grant;
    logic [PTR_W-1:0]    grant_idx;
    wb_req_t             acc;
    logic                acc_vld;
    logic                retire_vld;
    logic                claim_fire;
    logic                underflow;
    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic [REG_ADDR_W-1:0] q_addr [3];
    logic [2:0]          hit_wb;
    logic [2:0]          cnt_nz;
    logic [2:0]          busy;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Nothing is accepted while reset is held, so no transfer can leak through it.
    assign req_ready = grant & {NREQ{rst}};
    assign acc_vld   = rst && (|grant);

    // Steer the granted requester's address and data onto the accept path.
    always_comb begin
        acc = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                acc.addr = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                acc.data = req_data[i*REG_DATA_W +: REG_DATA_W];
            end
        end
    end

    // Writes to r0 are consumed but never reach the register file or the scoreboard.
    assign retire_vld = acc_vld && (acc.addr != REG_ZERO);

    // A saturated counter can still take a claim if a retire to the same register lands this cycle.
    assign claim_ready = (claim_addr == REG_ZERO)
                      || (cnt[claim_addr] != CNT_MAX)
                      || (retire_vld && (acc.addr == claim_addr));
    assign claim_fire  = claim_valid && claim_ready && (claim_addr != REG_ZERO);

    assign inc_vec = claim_fire ? (NUM_REGS'(1) << claim_addr) : '0;
    assign dec_vec = retire_vld ? (NUM_REGS'(1) << acc.addr)   : '0;

    // Retiring a register with nothing outstanding is a requester protocol violation.
    assign underflow = retire_vld && (cnt[acc.addr] == '0) && !inc_vec[acc.addr];

    // Registered write port plus round-robin pointer advance on every accepted transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_din  <= '0;
            ptr     <= '0;
        end else begin
            wb_we <= retire_vld;
            if (acc_vld) begin
                wb_addr <= acc.addr;
                wb_din  <= acc.data;
                ptr     <= PTR_W'(rr_next(int'(grant_idx), NREQ));
            end
        end
    end

    // Per-register outstanding-write counters; simultaneous claim and retire cancel out.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    cnt[r] <= cnt[r] + 1'b1;
                end else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

`ifndef SYNTHESIS
    // Catch a retire with no matching claim while simulating.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!underflow);
        end
    end
`endif

    assign q_addr[0] = q_addr_a;
    assign q_addr[1] = q_addr_b;
    assign q_addr[2] = q_addr_c;

    // The write sitting on wb_* is not yet in the register file, so it still counts unless forwarded.
    always_comb begin
        for (int x = 0; x < 3; x++) begin
            hit_wb[x] = wb_we && (wb_addr == q_addr[x]) && (q_addr[x] != REG_ZERO);
            cnt_nz[x] = (q_addr[x] != REG_ZERO) && (cnt[q_addr[x]] != '0);
`ifdef REGFILE_WB_ARB_BYPASS_EN
            busy[x]   = cnt_nz[x];
`else
            busy[x]   = cnt_nz[x] || hit_wb[x];
`endif
        end
    end

    assign q_busy_a = busy[0];
    assign q_busy_b = busy[1];
    assign q_busy_c = busy[2];

`ifdef REGFILE_WB_ARB_BYPASS_EN
    // Forward the in-flight write data to any read port that matches it.
    always_comb begin
        q_fwd      = hit_wb;
        q_fwd_data = '0;
        for (int x = 0; x < 3; x++) begin
            if (hit_wb[x]) begin
                q_fwd_data[x*REG_DATA_W +: REG_DATA_W] = wb_din;
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req_valid;
    logic [2:0]    req_ready;
    logic [14:0]   req_addr;
    logic [95:0]   req_data;
    logic          claim_valid;
    logic [4:0]    claim_addr;
    logic          claim_ready;
    logic [4:0]    q_addr_a, q_addr_b, q_addr_c;
    logic          q_busy_a, q_busy_b, q_busy_c;
    logic          wb_we;
    logic [4:0]    wb_addr;
    logic [31:0]   wb_din;
`ifdef REGFILE_WB_ARB_BYPASS_EN
    logic [2:0]    q_fwd;
    logic [95:0]   q_fwd_data;
`endif

    regfile_wb_arbiter #(.NREQ(NREQ), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .claim_valid(claim_valid), .claim_addr(claim_addr), .claim_ready(claim_ready),
        .q_addr_a(q_addr_a), .q_addr_b(q_addr_b), .q_addr_c(q_addr_c),
        .q_busy_a(q_busy_a), .q_busy_b(q_busy_b), .q_busy_c(q_busy_c),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_din(wb_din)
`ifdef REGFILE_WB_ARB_BYPASS_EN
        , .q_fwd(q_fwd), .q_fwd_data(q_fwd_data)
`endif
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    int            exp_grant [$];
    logic [36:0]   exp_wb [$];
    int            mon_g;
    logic [36:0]   mon_w;
    int            w;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic claim(input logic [4:0] a, input logic exp_rdy);
        claim_valid = 1'b1;
        claim_addr  = a;
        @(negedge clk);
        check("claim_ready", {31'd0, claim_ready}, {31'd0, exp_rdy});
        next_cycle();
        claim_valid = 1'b0;
    endtask

    // Issue one write from requester i and wait (bounded) for its acceptance.
    task automatic do_write(input int i, input logic [4:0] a, input logic [31:0] d, output int waited);
        bit got;
        got = 1'b0;
        waited = 0;
        exp_grant.push_back(i);
        if (a != 5'd0) exp_wb.push_back({a, d});
        req_addr[i*5 +: 5]   = a;
        req_data[i*32 +: 32] = d;
        req_valid[i]         = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
            else waited++;
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL write_timeout: requester %0d got no ready, required ready within 20 cycles", i);
        end
        next_cycle();
        req_valid[i] = 1'b0;
    endtask

    // Monitor: every accepted transfer and every register-file write is checked against the queues.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    n_vec++;
                    if (exp_grant.size() == 0) begin
                        n_err++;
                        $display("FAIL grant_unexpected: got grant %0d, required none", i);
                    end else begin
                        mon_g = exp_grant.pop_front();
                        if (mon_g != i) begin
                            n_err++;
                            $display("FAIL grant_order: got %0d required %0d", i, mon_g);
                        end
                    end
                end
            end
            if (wb_we) begin
                n_vec++;
                if (exp_wb.size() == 0) begin
                    n_err++;
                    $display("FAIL wb_unexpected: got addr %0d data %h, required no write", wb_addr, wb_din);
                end else begin
                    mon_w = exp_wb.pop_front();
                    if ({wb_addr, wb_din} !== mon_w) begin
                        n_err++;
                        $display("FAIL wb_write: got addr %0d data %h required addr %0d data %h",
                                 wb_addr, wb_din, mon_w[36:32], mon_w[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        // Reset with every input active.
        rst = 1'b0;
        req_valid = 3'b111;
        req_addr  = {5'd3, 5'd2, 5'd1};
        req_data  = {32'h3, 32'h2, 32'h1};
        claim_valid = 1'b1;
        claim_addr  = 5'd4;
        q_addr_a = 5'd4; q_addr_b = 5'd1; q_addr_c = 5'd2;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_wb_we", {31'd0, wb_we}, 32'd0);
            check("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
            check("rst_wb_din", wb_din, 32'd0);
            check("rst_busy", {29'd0, q_busy_a, q_busy_b, q_busy_c}, 32'd0);
            check("rst_req_ready", {29'd0, req_ready}, 32'd0);
        end
        next_cycle();
        req_valid = 3'b000;
        claim_valid = 1'b0;
        q_addr_a = 5'd0; q_addr_b = 5'd0; q_addr_c = 5'd0;
        rst = 1'b1;
        next_cycle();

        // Single write to r5, one-cycle latency, in-flight write counts as busy.
        q_addr_a = 5'd5;
        claim(5'd5, 1'b1);
        do_write(0, 5'd5, 32'hDEADBEEF, w);
        check("single_ready_same_cycle", w, 32'd0);
        @(negedge clk);
        check("single_wb_we", {31'd0, wb_we}, 32'd1);
        check("single_wb_addr", {27'd0, wb_addr}, 32'd5);
        check("single_wb_din", wb_din, 32'hDEADBEEF);
`ifdef REGFILE_WB_ARB_BYPASS_EN
        check("single_fwd_a", {31'd0, q_fwd[0]}, 32'd1);
        check("single_busy_a_fwd", {31'd0, q_busy_a}, 32'd0);
`else
        check("single_busy_inflight", {31'd0, q_busy_a}, 32'd1);
`endif
        next_cycle();
        @(negedge clk);
        check("single_wb_we_one_cycle", {31'd0, wb_we}, 32'd0);
        check("single_busy_after", {31'd0, q_busy_a}, 32'd0);
        next_cycle();

        // Write to r0: accepted, never written, never busy; moves ptr back to 0.
        q_addr_a = 5'd0;
        do_write(2, 5'd0, 32'h55555555, w);
        check("r0_ready", w, 32'd0);
        @(negedge clk);
        check("r0_wb_we", {31'd0, wb_we}, 32'd0);
        check("r0_busy", {31'd0, q_busy_a}, 32'd0);
        next_cycle();

        // Fairness: all three requesters valid continuously for six grants.
        for (int r = 10; r <= 12; r++) begin
            claim(5'(r), 1'b1);
            claim(5'(r), 1'b1);
        end
        for (int k = 0; k < 6; k++) begin
            exp_grant.push_back(k % 3);
            exp_wb.push_back({5'(10 + k % 3), 32'hA0 + 32'(k % 3)});
        end
        req_addr  = {5'd12, 5'd11, 5'd10};
        req_data  = {32'hA2, 32'hA1, 32'hA0};
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("fair_grant", {29'd0, req_ready}, 32'd1 << (k % 3));
            @(posedge clk);
        end
        #1;
        req_valid = 3'b000;
        next_cycle();
        q_addr_c = 5'd10;
        @(negedge clk);
        check("fair_scoreboard_clear", {31'd0, q_busy_c}, 32'd0);
        next_cycle();

        // Scoreboard on r7: two claims, two retires.
        q_addr_b = 5'd7;
        claim(5'd7, 1'b1);
        claim(5'd7, 1'b1);
        do_write(1, 5'd7, 32'h00000077, w);
        @(negedge clk);
        check("r7_busy_cnt1_wb", {31'd0, q_busy_b}, 32'd1);
        next_cycle();
        @(negedge clk);
        check("r7_busy_cnt1", {31'd0, q_busy_b}, 32'd1);
        next_cycle();
        do_write(1, 5'd7, 32'h00000078, w);
        @(negedge clk);
`ifdef REGFILE_WB_ARB_BYPASS_EN
        check("r7_last_fwd_b", {31'd0, q_fwd[1]}, 32'd1);
        check("r7_last_busy_fwd", {31'd0, q_busy_b}, 32'd0);
`else
        check("r7_last_busy_inflight", {31'd0, q_busy_b}, 32'd1);
`endif
        next_cycle();
        @(negedge clk);
        check("r7_idle", {31'd0, q_busy_b}, 32'd0);
        next_cycle();

        // Same-cycle claim and retire on r7 leaves the count at 1.
        claim(5'd7, 1'b1);
        exp_grant.push_back(0);
        exp_wb.push_back({5'd7, 32'h00000079});
        claim_valid = 1'b1;
        claim_addr  = 5'd7;
        req_addr[4:0]  = 5'd7;
        req_data[31:0] = 32'h00000079;
        req_valid[0]   = 1'b1;
        @(negedge clk);
        check("same_cycle_ready", {29'd0, req_ready}, 32'd1);
        check("same_cycle_claim_ready", {31'd0, claim_ready}, 32'd1);
        next_cycle();
        claim_valid = 1'b0;
        req_valid[0] = 1'b0;
        next_cycle();
        @(negedge clk);
        check("same_cycle_cnt_kept", {31'd0, q_busy_b}, 32'd1);
        next_cycle();
        do_write(0, 5'd7, 32'h0000007A, w);
        next_cycle();
        @(negedge clk);
        check("same_cycle_drained", {31'd0, q_busy_b}, 32'd0);
        next_cycle();

        // Saturation on r3 and claims to r0.
        q_addr_c = 5'd3;
        claim(5'd3, 1'b1);
        claim(5'd3, 1'b1);
        claim(5'd3, 1'b1);
        claim(5'd3, 1'b0);
        @(negedge clk);
        check("sat_busy", {31'd0, q_busy_c}, 32'd1);
        next_cycle();
        claim(5'd0, 1'b1);
        exp_grant.push_back(1);
        exp_wb.push_back({5'd3, 32'h00000033});
        claim_valid = 1'b1;
        claim_addr  = 5'd3;
        req_addr[9:5]   = 5'd3;
        req_data[63:32] = 32'h00000033;
        req_valid[1]    = 1'b1;
        @(negedge clk);
        check("sat_claim_with_retire", {31'd0, claim_ready}, 32'd1);
        next_cycle();
        claim_valid = 1'b0;
        req_valid[1] = 1'b0;
        do_write(2, 5'd3, 32'h00000034, w);
        do_write(2, 5'd3, 32'h00000035, w);
        do_write(2, 5'd3, 32'h00000036, w);
        next_cycle();
        @(negedge clk);
        check("sat_drained", {31'd0, q_busy_c}, 32'd0);
        next_cycle();

        // In-flight write to r9 seen on read port a.
        q_addr_a = 5'd9;
        claim(5'd9, 1'b1);
        do_write(0, 5'd9, 32'h12345678, w);
        @(negedge clk);
        check("r9_wb_din", wb_din, 32'h12345678);
`ifdef REGFILE_WB_ARB_BYPASS_EN
        check("bypass_fwd_a", {31'd0, q_fwd[0]}, 32'd1);
        check("bypass_fwd_data_a", q_fwd_data[31:0], 32'h12345678);
        check("bypass_busy_a", {31'd0, q_busy_a}, 32'd0);
`else
        check("r9_busy_inflight", {31'd0, q_busy_a}, 32'd1);
`endif
        next_cycle();

        repeat (3) next_cycle();
        check("grant_queue_empty", exp_grant.size(), 32'd0);
        check("wb_queue_empty", exp_wb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
